// File: rtl/apb_slave.sv
// APB register-file slave with programmable wait states.
// Byte-lane writes, address/alignment error reporting.
module apb_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sel,
  input  logic                    enable,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] strobe,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ready,
  output logic                    slverr
);

  localparam int STRB_SIZE = DATA_WIDTH / 8;
  localparam int LSB       = $clog2(STRB_SIZE);
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH + 1)'(DEPTH * STRB_SIZE);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ADDR_WIDTH'(STRB_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic                  cap_write;
  logic [STRB_SIZE-1:0]  cap_strobe;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic             err;
  logic [IDX_W-1:0] idx;
  logic             setup;
  logic             access;

  assign setup  = sel && !enable;
  assign access = sel && enable;

  // Decoding works only on the captured address.
  assign err = ({1'b0, cap_addr} >= LIMIT) ||
               ((cap_addr & ALIGN_MASK) != '0);
  assign idx = cap_addr[LSB +: IDX_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (setup) state_nxt = S_WAIT;
      S_WAIT: begin
        if (!sel)
          state_nxt = S_IDLE;
        else if (enable && cnt == 4'd0)
          state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready  = 1'b0;
    slverr = 1'b0;
    rdata  = '0;
    if (state == S_RESP) begin
      ready  = 1'b1;
      slverr = err;
      if (!err && !cap_write)
        rdata = mem[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      cap_addr   <= '0;
      cap_write  <= 1'b0;
      cap_strobe <= '0;
      cap_wdata  <= '0;
    end else begin
      if (state == S_IDLE && setup) begin
        cnt        <= 4'(WAIT_CYCLES);
        cap_addr   <= addr;
        cap_write  <= write;
        cap_strobe <= strobe;
        cap_wdata  <= wdata;
      end else if (state == S_WAIT && access && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Registers commit only on the edge that closes the response cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (state == S_RESP && cap_write && !err) begin
      for (int b = 0; b < STRB_SIZE; b++)
        if (cap_strobe[b])
          mem[idx][b*8 +: 8] <= cap_wdata[b*8 +: 8];
    end
  end

endmodule

// File: doc/apb_slave.md
APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width; STRB_SIZE = DATA_WIDTH/8.
REQ-003 SHALL have parameter DEPTH, default 16, number of DATA_WIDTH-bit registers, base address 0.
REQ-004 SHALL have parameter WAIT_CYCLES, default 1, wait states inserted before ready (0..15).
REQ-005 SHALL use one clock and an asynchronous, active-high reset (already decided).
REQ-006 SHALL have port: clk  input  1  clock, all state on rising edge.
REQ-007 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-008 SHALL have port: sel  input  1  APB select from master.
REQ-009 SHALL have port: enable  input  1  APB enable (access phase).
REQ-010 SHALL have port: write  input  1  1 = write, 0 = read.
REQ-011 SHALL have port: strobe  input  STRB_SIZE  byte-lane write enables.
REQ-012 SHALL have port: addr  input  ADDR_WIDTH  byte address.
REQ-013 SHALL have port: wdata  input  DATA_WIDTH  write data.
REQ-014 SHALL have port: rdata  output  DATA_WIDTH  read data, valid only while ready=1.
REQ-015 SHALL have port: ready  output  1  transfer completion, registered.
REQ-016 SHALL have port: slverr  output  1  transfer error, valid only while ready=1.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP; ready=1 only in RESP, for exactly one cycle per transfer.
REQ-018 IDLE: on a clock edge with sel=1, enable=0, SHALL capture addr, write, strobe, wdata, load wait counter with WAIT_CYCLES, go to WAIT; otherwise stay IDLE.
REQ-019 WAIT: on an edge with sel=1, enable=1: counter=0 -> RESP, else decrement and stay; sel=1, enable=0 -> hold counter, stay; sel=0 -> IDLE, transfer aborted, no register update.
REQ-020 RESP: next edge SHALL always go to IDLE; a following SETUP is sampled from IDLE, so back-to-back transfers incur no extra gap beyond the master's SETUP cycle.
REQ-021 Latency: ready SHALL rise WAIT_CYCLES+1 cycles after the first access-phase cycle (ACCESS phase length = WAIT_CYCLES+2).
REQ-022 Error condition: captured addr >= DEPTH*STRB_SIZE, or addr[log2(STRB_SIZE)-1:0] != 0; slverr=1 in RESP when error, else 0.
REQ-023 Word index SHALL be addr >> log2(STRB_SIZE) using captured address only; inputs changing after SETUP SHALL be ignored.
REQ-024 Write: at the edge ending RESP, when write=1 and no error, each byte lane i with strobe[i]=1 SHALL take wdata lane i; other lanes unchanged; strobe=0 -> no change, no error.
REQ-025 Write with error SHALL leave all registers unchanged.
REQ-026 Read: in RESP, rdata = register[index] when no error, 0 when error; strobe ignored for reads.
REQ-027 Outside RESP rdata, slverr, ready SHALL be 0.
REQ-028 A write followed immediately by a read of the same address SHALL return the newly written data.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, counter 0, captured fields 0, ready=0, slverr=0, rdata=0, all DEPTH registers 0.
REQ-030 Reset asserted mid-transfer SHALL abort it with no register update; first transfer after release behaves as from power-up.

Verification
REQ-031 Write addr 0x04, wdata 0xDEADBEEF, strobe 4'hF, WAIT_CYCLES=1; then read 0x04 -> ready after 3 access cycles, slverr=0, rdata=0xDEADBEEF.
REQ-032 Write 0x08 with 0x11223344 strobe 4'hF, then 0xAABBCCDD strobe 4'b0101; read 0x08 -> 0x11BB33DD.
REQ-033 Read 0x40 (DEPTH=16) and write 0x06 -> each slverr=1 with ready; read rdata=0; subsequent reads show no register changed.
REQ-034 WAIT_CYCLES=0 and 3: ready asserts on access cycle 2 and 5 respectively, held low before, single-cycle high.
REQ-035 sel dropped during WAIT of a write to 0x0C -> return to IDLE, ready never asserts, read 0x0C returns 0.
REQ-036 Assert rst during WAIT of a write to 0x00 after 0x00 held 0x12345678 -> outputs 0 immediately; read 0x00 after release returns 0.
